// File: rtl/trng_pkg.sv
// Shared definitions for the TRNG block: controller state encoding and the
// default modulus for 256-bit generation.
package trng_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WARMUP,
        ST_COLLECT,
        ST_CHECK,
        ST_FAIL
    } trng_state_e;

    localparam logic [255:0] TRNG_P_DEFAULT =
        256'hffffffff00000001000000000000000000000000ffffffffffffffffffffffff;

endpackage : trng_pkg

// File: rtl/trng_rct.sv
// Repetition-count health test: flags a run of LIMIT identical consecutive
// samples in the same cycle as the offending sample.
module trng_rct #(
    parameter int SAMP_W = 16,
    parameter int LIMIT  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              valid_i,
    input  logic [SAMP_W-1:0] sample_i,
    output logic              fail_o
);

    localparam int RW = $clog2(LIMIT + 1);

    logic [SAMP_W-1:0] prev_q;
    logic [RW-1:0]     run_q, run_d;

    // NOTE: every signal assigned here gets a default first, otherwise the
    // untaken branches would infer latches.
    always_comb begin
        run_d  = run_q;
        fail_o = 1'b0;
        if (clr_i) begin
            run_d = '0;
        end else if (valid_i) begin
            // run_q == 0 means no sample seen since the last start
            if (run_q != '0 && sample_i == prev_q) begin
                run_d = (run_q == RW'(LIMIT)) ? run_q : run_q + RW'(1);
            end else begin
                run_d = RW'(1);
            end
            fail_o = (run_d == RW'(LIMIT));
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_q  <= '0;
            prev_q <= '0;
        end else begin
            run_q <= run_d;
            if (valid_i) prev_q <= sample_i;
        end
    end

endmodule : trng_rct

// File: rtl/trng_gen.sv
// Rejection-sampling TRNG: warm-up discard, repetition-count health test,
// value < P enforcement and a word-addressed result memory for the bus.
module trng_gen
    import trng_pkg::*;
#(
    parameter int               OUT_W     = 256,
    parameter int               SAMP_W    = 16,
    parameter int               WORD_W    = 32,
    parameter logic [OUT_W-1:0] P         = OUT_W'(TRNG_P_DEFAULT),
    parameter int               DISCARD   = 4,
    parameter int               RCT_LIMIT = 4,
    parameter int               MAX_RETRY = 15,
    localparam int              NSAMP     = OUT_W / SAMP_W,
    localparam int              WORDS     = OUT_W / WORD_W,
    localparam int              AW        = (WORDS > 2) ? $clog2(WORDS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [SAMP_W-1:0] samp_in,
    input  logic              samp_valid,
    output logic              samp_en,
    input  logic              rd_en,
    input  logic [AW-1:0]     addr,
    output logic [WORD_W-1:0] out,
    output logic              rdy,
    output logic              health_fail,
    input  logic              fail_clr,
    output logic [7:0]        reject_cnt
);

    localparam int CMAX = (DISCARD > NSAMP) ? DISCARD : NSAMP;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int RTW  = $clog2(MAX_RETRY + 2);
    localparam logic [AW:0] WORDS_A = (AW + 1)'(WORDS);

    trng_state_e       state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;
    logic [RTW-1:0]    retry_q, retry_d;
    logic [OUT_W-1:0]  shreg_q, shreg_d;
    logic [7:0]        rej_q, rej_d;
    logic              hf_q, hf_d;
    logic              rdy_q, samp_en_q;
    logic [WORD_W-1:0] out_q, rd_word;
    logic [WORD_W-1:0] mem_q [WORDS];
    logic              sampling, start, commit, rct_fail;

    assign sampling = (state_q == ST_WARMUP) || (state_q == ST_COLLECT);
    assign start    = (state_q == ST_IDLE) && en && !hf_q;
    assign cnt_inc  = cnt_q + CW'(1);

    trng_rct #(
        .SAMP_W (SAMP_W),
        .LIMIT  (RCT_LIMIT)
    ) u_rct (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (start),
        .valid_i  (samp_valid && sampling),
        .sample_i (samp_in),
        .fail_o   (rct_fail)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        shreg_d = shreg_q;
        rej_d   = rej_q;
        hf_d    = hf_q;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cnt_d   = '0;
                    retry_d = '0;
                    state_d = (DISCARD == 0) ? ST_COLLECT : ST_WARMUP;
                end
            end
            ST_WARMUP: begin
                if (samp_valid) begin
                    if (cnt_inc == CW'(DISCARD)) begin
                        cnt_d   = '0;
                        state_d = ST_COLLECT;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            ST_COLLECT: begin
                if (samp_valid) begin
                    // first sample of a value ends up in the MSBs
                    shreg_d = {shreg_q[OUT_W-SAMP_W-1:0], samp_in};
                    if (cnt_inc == CW'(NSAMP)) begin
                        cnt_d   = '0;
                        state_d = ST_CHECK;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            ST_CHECK: begin
                if (shreg_q < P) begin
                    commit  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    if (rej_q != 8'hff) rej_d = rej_q + 8'd1;
                    retry_d = retry_q + RTW'(1);
                    state_d = (retry_d > RTW'(MAX_RETRY)) ? ST_FAIL : ST_COLLECT;
                end
            end
            ST_FAIL: begin
                if (fail_clr) begin
                    state_d = ST_IDLE;
                    hf_d    = 1'b0;
                end else begin
                    hf_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (rct_fail) state_d = ST_FAIL;
    end

    always_comb begin
        rd_word = '0;
        if ({1'b0, addr} < WORDS_A) rd_word = mem_q[addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            retry_q   <= '0;
            shreg_q   <= '0;
            rej_q     <= '0;
            hf_q      <= 1'b0;
            rdy_q     <= 1'b1;
            samp_en_q <= 1'b0;
            out_q     <= '0;
            // NOTE: the result memory is reset word by word because a reset
            // must leave no trace of a previously generated secret.
            for (int i = 0; i < WORDS; i++) mem_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            shreg_q   <= shreg_d;
            rej_q     <= rej_d;
            hf_q      <= hf_d;
            rdy_q     <= (state_d == ST_IDLE);
            samp_en_q <= (state_d == ST_WARMUP) || (state_d == ST_COLLECT);
            if (commit) begin
                for (int i = 0; i < WORDS; i++) mem_q[i] <= shreg_q[i*WORD_W +: WORD_W];
            end
            if (rd_en && rdy_q) out_q <= rd_word;
        end
    end

    assign samp_en     = samp_en_q;
    assign rdy         = rdy_q;
    assign health_fail = hf_q;
    assign reject_cnt  = rej_q;
    assign out         = out_q;

endmodule : trng_gen
